bash_f_ctrl: RTL



---
 rtl/bash_pkg.sv | 13 +
 rtl/bash_f_ctrl_if.sv | 23 ++
 rtl/bash_f_ctrl.sv | 90 +++++++++
 3 files changed

// File: rtl/bash_pkg.sv
// Shared BASH constants and types used by the BASH-F permutation core and its controller.
package bash_pkg;
    localparam int BASH_W      = 1536;
    localparam int BASH_ROUNDS = 24;
    localparam logic [63:0] BASH_C0 = 64'hB194BAC80A08F53B;

    typedef logic [BASH_W-1:0] bash_state_t;

    typedef enum logic {
        IDLE,
        RUN
    } bash_f_ctrl_state_t;
endpackage

// File: rtl/bash_f_ctrl_if.sv
// Job-in / result-out valid/ready handshakes between the sponge front-end and bash_f_ctrl.
interface bash_f_ctrl_if
    import bash_pkg::*;
#(
    parameter int W = BASH_W
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/bash_f_ctrl.sv
// Sequencer for the iterative BASH-F datapath: accepts a state, runs ROUNDS rounds of
// feedback through bash_f_iter, then holds the final state in a result register.
module bash_f_ctrl
    import bash_pkg::*;
#(
    parameter int  W      = BASH_W,
    parameter int  ROUNDS = BASH_ROUNDS,
    localparam int CW     = $clog2(ROUNDS + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          abort,
    bash_f_ctrl_if.slave  bus,
    output logic          busy,
    output logic [CW-1:0] round,
    output logic          iter_sel,
    output logic [W-1:0]  iter_data_i,
    input  logic [W-1:0]  iter_data_o
);
    localparam logic [CW-1:0] LAST = CW'(ROUNDS);

    bash_f_ctrl_state_t state, state_nxt;
    logic [CW-1:0]      round_nxt;
    logic               accept;
    logic               capture;
    logic               out_valid_q;
    logic [W-1:0]       out_data_q;

    // Only accept when the result slot is free or draining now, so capture never collides.
    assign bus.in_ready  = (state == IDLE) && !abort && (!out_valid_q || bus.out_ready);
    assign accept        = bus.in_valid && bus.in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign busy          = (state == RUN);
    assign iter_sel      = (state == RUN);
    assign iter_data_i   = bus.in_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            round <= '0;
        end else begin
            state <= state_nxt;
            round <= round_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        round_nxt = round;
        capture   = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = RUN;
                    round_nxt = CW'(1);
                end
            end
            RUN: begin
                if (abort) begin
                    state_nxt = IDLE;
                    round_nxt = '0;
                end else if (round == LAST) begin
                    state_nxt = IDLE;
                    round_nxt = '0;
                    capture   = 1'b1;
                end else begin
                    round_nxt = round + CW'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                round_nxt = '0;
            end
        endcase
    end

    // Result register holds until the consumer takes it; abort leaves it untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else if (capture) begin
            out_valid_q <= 1'b1;
            out_data_q  <= iter_data_o;
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end
endmodule
